// File: rtl/wts_multi_envelope_generator.sv
// Time-multiplexed ADSR envelope generator; one channel is serviced per active pulse.
// Optional feature macro WTS_ENV_REPEAT_EN: SUSTAIN reaching 0 re-enters ATTACK when REPEAT=1.
module wts_multi_envelope_generator #(
  parameter int CH      = 5,
  parameter int LEVEL_W = 8,
  parameter int RATE_W  = 12
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  active,
  input  logic [CH-1:0]         key_on,
  input  logic [CH-1:0]         key_release,
  input  logic [CH-1:0]         key_off,
  input  logic                  reg_wr,
  input  logic [3:0]            reg_ch,
  input  logic [2:0]            reg_sel,
  input  logic [RATE_W-1:0]     reg_data,
  output logic [CH*LEVEL_W-1:0] envelope,
  output logic [CH-1:0]         busy
);
  typedef enum logic [2:0] {ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE} state_e;

  localparam logic [LEVEL_W-1:0] MAX_LVL   = {1'b1, {(LEVEL_W-1){1'b0}}};
  localparam logic [LEVEL_W-1:0] LVL_ONE   = {{(LEVEL_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]         LAST_SLOT = 4'(CH-1);

  logic [3:0]            slot_q, slot_d;
  logic [CH-1:0]         on_pend_q, on_pend_d, rel_pend_q, rel_pend_d, off_pend_q, off_pend_d;
  state_e                state_q [CH];
  state_e                state_d [CH];
  logic [15:0]           cnt_q [CH];
  logic [15:0]           cnt_d [CH];
  logic [LEVEL_W-1:0]    level_q [CH];
  logic [LEVEL_W-1:0]    level_d [CH];
  logic [RATE_W-1:0]     ar_q [CH], dr_q [CH], sr_q [CH], rr_q [CH];
  logic [RATE_W-1:0]     ar_d [CH], dr_d [CH], sr_d [CH], rr_d [CH];
  logic [LEVEL_W-2:0]    sl_q [CH];
  logic [LEVEL_W-2:0]    sl_d [CH];
`ifdef WTS_ENV_REPEAT_EN
  logic [CH-1:0]         rep_q, rep_d;
  logic                  cur_rep;
`endif
  logic [CH*LEVEL_W-1:0] envelope_q, envelope_d;
  logic [CH-1:0]         busy_q, busy_d, svc_mask;

  // Fields of the channel addressed by the slot, shared by one update datapath.
  state_e             cur_state, nxt_state;
  logic [15:0]        cur_cnt, nxt_cnt;
  logic [LEVEL_W-1:0] cur_lvl, nxt_lvl;
  logic [RATE_W-1:0]  cur_ar, cur_rate;
  logic [LEVEL_W-2:0] cur_sl;
  logic               cur_on, cur_rel, cur_off;

  // NOTE: every variable gets a default before any branch, so no latch can be inferred.
  always_comb begin
    svc_mask  = '0;
    cur_state = ST_IDLE;
    cur_cnt   = '0;
    cur_lvl   = '0;
    cur_ar    = '0;
    cur_rate  = '0;
    cur_sl    = '0;
    cur_on    = 1'b0;
    cur_rel   = 1'b0;
    cur_off   = 1'b0;
`ifdef WTS_ENV_REPEAT_EN
    cur_rep   = 1'b0;
`endif
    for (int i = 0; i < CH; i++) begin
      if (slot_q == 4'(i)) begin
        svc_mask[i] = active;
        cur_state   = state_q[i];
        cur_cnt     = cnt_q[i];
        cur_lvl     = level_q[i];
        cur_ar      = ar_q[i];
        cur_sl      = sl_q[i];
        cur_on      = on_pend_q[i];
        cur_rel     = rel_pend_q[i];
        cur_off     = off_pend_q[i];
`ifdef WTS_ENV_REPEAT_EN
        cur_rep     = rep_q[i];
`endif
        case (state_q[i])
          ST_ATTACK:  cur_rate = ar_q[i];
          ST_DECAY:   cur_rate = dr_q[i];
          ST_SUSTAIN: cur_rate = sr_q[i];
          ST_RELEASE: cur_rate = rr_q[i];
          default:    cur_rate = '0;
        endcase
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    nxt_lvl   = cur_lvl;
    if (cur_off) begin
      nxt_state = ST_IDLE;
      nxt_lvl   = '0;
    end else if (cur_on) begin
      nxt_state = ST_ATTACK;
      nxt_cnt   = 16'({cur_ar, 4'b0000});
      nxt_lvl   = (cur_ar == '0) ? MAX_LVL : '0;
    end else if (cur_rel && cur_state != ST_IDLE) begin
      nxt_state = ST_RELEASE;
    end else if (cur_state != ST_IDLE) begin
      // A zero rate reloads zero, so the counter parks at 0 and the level holds.
      if (cur_cnt == '0) begin
        nxt_cnt = 16'({cur_rate, 4'b0000});
        if (cur_rate != '0) begin
          if (cur_state == ST_ATTACK) begin
            if (cur_lvl < MAX_LVL) nxt_lvl = cur_lvl + LVL_ONE;
          end else if (cur_lvl != '0) begin
            nxt_lvl = cur_lvl - LVL_ONE;
          end
        end
      end else begin
        nxt_cnt = cur_cnt - 16'd1;
      end
      case (cur_state)
        ST_ATTACK:  if (nxt_lvl == MAX_LVL) nxt_state = ST_DECAY;
        ST_DECAY:   if (nxt_lvl <= {1'b0, cur_sl}) nxt_state = ST_SUSTAIN;
        ST_SUSTAIN: if (nxt_lvl == '0) begin
`ifdef WTS_ENV_REPEAT_EN
          if (cur_rep) begin
            nxt_state = ST_ATTACK;
            nxt_cnt   = 16'({cur_ar, 4'b0000});
            nxt_lvl   = (cur_ar == '0) ? MAX_LVL : '0;
          end else
`endif
          nxt_state = ST_IDLE;
        end
        ST_RELEASE: if (nxt_lvl == '0) nxt_state = ST_IDLE;
        default:    nxt_state = cur_state;
      endcase
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (active) slot_d = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
    // Service consumes the registered pending bits; a pulse on the service edge survives.
    on_pend_d  = (on_pend_q  & ~svc_mask) | key_on;
    rel_pend_d = (rel_pend_q & ~svc_mask) | key_release;
    off_pend_d = (off_pend_q & ~svc_mask) | key_off;
    envelope_d = '0;
    busy_d     = '0;
`ifdef WTS_ENV_REPEAT_EN
    rep_d      = rep_q;
`endif
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      ar_d[i]    = ar_q[i];
      dr_d[i]    = dr_q[i];
      sr_d[i]    = sr_q[i];
      rr_d[i]    = rr_q[i];
      sl_d[i]    = sl_q[i];
      if (svc_mask[i]) begin
        state_d[i] = nxt_state;
        cnt_d[i]   = nxt_cnt;
        level_d[i] = nxt_lvl;
      end
      if (reg_wr && reg_ch == 4'(i)) begin
        case (reg_sel)
          3'd0:    ar_d[i] = reg_data;
          3'd1:    dr_d[i] = reg_data;
          3'd2:    sr_d[i] = reg_data;
          3'd3:    rr_d[i] = reg_data;
          3'd4:    sl_d[i] = reg_data[LEVEL_W-2:0];
`ifdef WTS_ENV_REPEAT_EN
          3'd5:    rep_d[i] = reg_data[0];
`endif
          default: ;
        endcase
      end
      envelope_d[i*LEVEL_W +: LEVEL_W] = level_q[i];
      busy_d[i] = (state_q[i] != ST_IDLE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q     <= '0;
      on_pend_q  <= '0;
      rel_pend_q <= '0;
      off_pend_q <= '0;
      envelope_q <= '0;
      busy_q     <= '0;
`ifdef WTS_ENV_REPEAT_EN
      rep_q      <= '0;
`endif
      // NOTE: the per-channel arrays, rate registers included, are reset so a key-on before any write is defined.
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        level_q[i] <= '0;
        ar_q[i]    <= '0;
        dr_q[i]    <= '0;
        sr_q[i]    <= '0;
        rr_q[i]    <= '0;
        sl_q[i]    <= '0;
      end
    end else begin
      slot_q     <= slot_d;
      on_pend_q  <= on_pend_d;
      rel_pend_q <= rel_pend_d;
      off_pend_q <= off_pend_d;
      envelope_q <= envelope_d;
      busy_q     <= busy_d;
`ifdef WTS_ENV_REPEAT_EN
      rep_q      <= rep_d;
`endif
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        level_q[i] <= level_d[i];
        ar_q[i]    <= ar_d[i];
        dr_q[i]    <= dr_d[i];
        sr_q[i]    <= sr_d[i];
        rr_q[i]    <= rr_d[i];
        sl_q[i]    <= sl_d[i];
      end
    end
  end

  assign envelope = envelope_q;
  assign busy     = busy_q;

endmodule
